// File: rtl/bnn_weight_streamer.sv
// Streams NUM_NEURONS weight bytes into the BNN core's weight-load port, low nibble first.
// Optional checksum stage is compiled in with `define BNN_WSTREAM_CHECKSUM_EN.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 12,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [3:0]       wt_nibble,
  output logic             wt_load_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] neuron_count,
  output logic             csum_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LO,
    S_HI,
`ifdef BNN_WSTREAM_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NEURONS - 1);

  state_t     state;
  logic [7:0] wbuf;

`ifdef BNN_WSTREAM_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       csum_err_q;
  assign csum_err = csum_err_q;
`else
  assign csum_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wbuf         <= '0;
      neuron_count <= '0;
      aborted      <= 1'b0;
`ifdef BNN_WSTREAM_CHECKSUM_EN
      sum_q        <= '0;
      csum_err_q   <= 1'b0;
`endif
    end else if (ena) begin
      case (state)
        S_IDLE: if (start) state <= S_WAIT;
        // A byte arriving with abort wins: the core must never be left mid-byte.
        S_WAIT: begin
          if (byte_valid) begin
            wbuf  <= byte_data;
            state <= S_LO;
`ifdef BNN_WSTREAM_CHECKSUM_EN
            sum_q <= sum_q + byte_data;
`endif
          end else if (abort) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_LO: state <= S_HI;
        S_HI: begin
          neuron_count <= neuron_count + CNT_W'(1);
          if (neuron_count == LAST)
`ifdef BNN_WSTREAM_CHECKSUM_EN
            state <= S_CHECK;
`else
            state <= S_DONE;
`endif
          else
            state <= S_WAIT;
        end
`ifdef BNN_WSTREAM_CHECKSUM_EN
        S_CHECK: begin
          if (byte_valid) begin
            csum_err_q <= ((sum_q + byte_data) != 8'd0);
            state      <= S_DONE;
          end else if (abort) begin
            aborted <= 1'b1;
            state   <= S_DONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Handshake and strobe are gated by ena so a frozen cycle never reaches the core.
  always_comb begin
    byte_ready = 1'b0;
    wt_load_en = 1'b0;
    busy       = 1'b0;
    case (state)
      S_WAIT: begin byte_ready = ena; busy = 1'b1; end
      S_LO, S_HI: begin wt_load_en = ena; busy = 1'b1; end
`ifdef BNN_WSTREAM_CHECKSUM_EN
      S_CHECK: begin byte_ready = ena; busy = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign done      = (state == S_DONE);
  assign wt_nibble = !wt_load_en ? 4'h0 : (state == S_LO) ? wbuf[3:0] : wbuf[7:4];

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Randomised self-checking bench for bnn_weight_streamer; nibble stream checked against a byte-level scoreboard.
module tb_bnn_weight_streamer;
  localparam int NUM = 12;
  localparam int CW  = 5;

  logic          clk = 1'b0, rst_n = 1'b0, ena = 1'b0, start = 1'b0, abort = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready, wt_load_en, busy, done, aborted, csum_err;
  logic [3:0]    wt_nibble;
  logic [CW-1:0] neuron_count;

  int vectors = 0, miscompares = 0;
  bit rnd_ena = 0;

  always #5 clk = ~clk;

  bnn_weight_streamer #(.NUM_NEURONS(NUM), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wt_nibble(wt_nibble), .wt_load_en(wt_load_en), .busy(busy), .done(done),
    .aborted(aborted), .neuron_count(neuron_count), .csum_err(csum_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, want, $time);
    end
  endtask

  // Scoreboard: every accepted weight byte owes the core two strobes, due a fixed
  // number of enabled cycles after its handshake.
  typedef struct { logic [3:0] nib; bit hi; int due; } exp_t;
  exp_t q[$];
  int   cyc = 0, gap = 0, n_acc = 0, n_emit = 0, t_first_hs = 0, t_full = 0;
  bit   full_seen = 0, exp_csum_err = 0;
  logic [7:0] sum = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete(); n_acc = 0; n_emit = 0; sum = 0; exp_csum_err = 0; full_seen = 0;
    end else begin
      if (!ena) begin
        gap++;
        chk("gated_ready", byte_ready, 0);
        chk("gated_load", wt_load_en, 0);
      end
      chk("count", neuron_count, n_emit);
      if (!full_seen && neuron_count == NUM) begin full_seen = 1; t_full = cyc; end
      if (wt_load_en) begin
        if (q.size() == 0) chk("extra_strobe", 1, 0);
        else begin
          e = q.pop_front();
          chk("nibble", wt_nibble, e.nib);
          chk("strobe_cyc", cyc, e.due + gap);
          if (e.hi) n_emit++;
        end
      end else chk("idle_nibble", wt_nibble, 0);
      if (byte_valid && byte_ready) begin
        if (n_acc < NUM) begin
          if (n_acc == 0) t_first_hs = cyc;
          q.push_back('{byte_data[3:0], 1'b0, cyc + 1 - gap});
          q.push_back('{byte_data[7:4], 1'b1, cyc + 2 - gap});
          sum = sum + byte_data;
        end else exp_csum_err = ((sum + byte_data) != 8'd0);
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_ena) ena = ($urandom_range(0, 5) != 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; start = 0; abort = 0; byte_valid = 0;
    #1;
    chk("rst_load", wt_load_en, 0); chk("rst_nib", wt_nibble, 0);
    chk("rst_ready", byte_ready, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_abort", aborted, 0);
    chk("rst_count", neuron_count, 0); chk("rst_csum", csum_err, 0);
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    ena = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep);
    bit acc = 0;
    byte_data = b; byte_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = byte_ready;
      tick();
    end
    if (!acc) chk("hs_timeout", 0, 1);
    if (!keep) byte_valid = 1'b0;
  endtask

  // mode 0: 0..n-1 with valid held; 1: random bytes, random gaps; 2: 0xB7, 5-cycle gaps; 3: 0x01
  task automatic load_bytes(input int mode, input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = (mode == 0) ? k[7:0] : (mode == 2) ? 8'hB7 : (mode == 3) ? 8'h01 : 8'($urandom);
      send_byte(b, mode == 0);
      if (mode == 1) repeat ($urandom_range(0, 3)) tick();
      if (mode == 2 && k < n - 1) begin
        tick(); tick();
        repeat (3) begin @(negedge clk); chk("ready_in_gap", byte_ready, 1); tick(); end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk); seen = done; end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic end_checks(input bit exp_ab, input int exp_cnt);
    wait_done();
    rnd_ena = 0; ena = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("end_done", done, 1); chk("end_busy", busy, 0); chk("end_ready", byte_ready, 0);
    chk("end_aborted", aborted, exp_ab); chk("end_count", neuron_count, exp_cnt);
    chk("end_queue", q.size(), 0); chk("end_csum", csum_err, exp_csum_err);
  endtask

  task automatic send_csum();
`ifdef BNN_WSTREAM_CHECKSUM_EN
    send_byte(8'(-sum), 0);
`endif
  endtask

  initial begin
    do_reset();

    // Sequential bytes, valid held high: fixed 3-cycle cadence.
    do_start();
    load_bytes(0, NUM);
    send_csum();
    end_checks(0, NUM);
    chk("first_hs_to_full", t_full - t_first_hs, 36);

    // Same byte with valid gaps.
    do_reset(); do_start();
    load_bytes(2, NUM);
    send_csum();
    end_checks(0, NUM);

    // Enable dropped during the low-nibble strobe.
    do_reset(); do_start();
    send_byte(8'hA5, 0);
    ena = 1'b0;
    repeat (3) begin @(negedge clk); chk("ena_gap_load", wt_load_en, 0); @(posedge clk); #1; end
    ena = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("ena_count", neuron_count, 1); chk("ena_queue", q.size(), 0);

    // Abort raised while byte 3's low nibble is on the bus.
    do_reset(); do_start();
    load_bytes(0, 4);
    abort = 1'b1;
    end_checks(1, 4);
    abort = 1'b0;
    do_start();
    repeat (3) tick();
    @(negedge clk);
    chk("restart_ignored_busy", busy, 0); chk("restart_ignored_cnt", neuron_count, 4);

    // Reset during byte 6's high nibble, then a full clean load.
    do_reset(); do_start();
    load_bytes(0, 7);
    tick();
    chk("pre_rst_load", wt_load_en, 1);
    do_reset(); do_start();
    load_bytes(1, NUM);
    send_csum();
    end_checks(0, NUM);

    // Random loads with random enable and random abort points.
    for (int r = 0; r < 8; r++) begin
      int nb;
      nb = (r % 2) ? $urandom_range(0, NUM - 1) : NUM;
      do_reset(); do_start();
      rnd_ena = 1;
      load_bytes(1, nb);
      if (nb == NUM) begin send_csum(); end_checks(0, NUM); end
      else begin abort = 1'b1; end_checks(1, nb); abort = 1'b0; end
    end

`ifdef BNN_WSTREAM_CHECKSUM_EN
    for (int g = 0; g < 2; g++) begin
      do_reset(); do_start();
      load_bytes(3, NUM);
      repeat (3) tick();
      @(negedge clk);
      chk("check_busy", busy, 1); chk("check_ready", byte_ready, 1); chk("check_done", done, 0);
      @(posedge clk); #1;
      send_byte((g == 0) ? 8'hF4 : 8'hF5, 0);
      end_checks(0, NUM);
      chk("csum_result", csum_err, g);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
